// File: rtl/scl180_spare_pkg.sv
// Shared constants and chain-op encoding for the SCL180 spare-cell bank.
// Imported by scl180_spare_cnt and scl180_macro_sparecell_bank.
package scl180_spare_pkg;

   localparam int SPARE_NUM_TIE_DEF   = 4;
   localparam int SPARE_DEPTH_DEF     = 8;
   localparam int SPARE_CNT_WIDTH_DEF = 8;

   // Shift-chain operation, highest priority last
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_SHIFT = 2'd1,
      OP_CLR   = 2'd2
   } chain_op_e;

endpackage

// File: rtl/scl180_spare_cnt.sv
// Spare loadable up-counter with registered terminal-count pulse.
// Ports: clk, resetn (async low), cnt_en, cnt_load, cnt_din -> cnt_q, cnt_tc.
module scl180_spare_cnt
   import scl180_spare_pkg::*;
#(
   parameter int CNT_WIDTH = SPARE_CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 cnt_en,
   input  logic                 cnt_load,
   input  logic [CNT_WIDTH-1:0] cnt_din,
   output logic [CNT_WIDTH-1:0] cnt_q,
   output logic                 cnt_tc
);

   localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] count_d;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 tc_d;
   logic                 tc_q;

   // Load beats increment; tc only marks an increment that wraps
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (cnt_load) begin
         count_d = cnt_din;
      end else if (cnt_en) begin
         count_d = count_q + ONE;
         tc_d    = &count_q;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign cnt_q  = count_q;
   assign cnt_tc = tc_q;

endmodule

// File: rtl/scl180_macro_sparecell_bank.sv
// ECO spare-logic bank: tie buses, spare shift chain, spare counter.
// Ports: clk, resetn, sh_* chain, cnt_* counter, LO/HI ties; macros USE_POWER_PINS, SCL180_SPARE_GATES_EN.
module scl180_macro_sparecell_bank
   import scl180_spare_pkg::*;
#(
   parameter int NUM_TIE   = SPARE_NUM_TIE_DEF,
   parameter int DEPTH     = SPARE_DEPTH_DEF,
   parameter int CNT_WIDTH = SPARE_CNT_WIDTH_DEF
) (
`ifdef USE_POWER_PINS
   input  logic                 VPWR,
   input  logic                 VGND,
`endif
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 sh_en,
   input  logic                 sh_clr,
   input  logic                 sh_in,
   output logic                 sh_out,
   output logic [DEPTH-1:0]     sh_par,
   input  logic                 cnt_en,
   input  logic                 cnt_load,
   input  logic [CNT_WIDTH-1:0] cnt_din,
   output logic [CNT_WIDTH-1:0] cnt_q,
   output logic                 cnt_tc,
`ifdef SCL180_SPARE_GATES_EN
   output logic [NUM_TIE-1:0]   spare_inv,
   output logic [NUM_TIE-1:0]   spare_nand,
   output logic [NUM_TIE-1:0]   spare_nor,
`endif
   output logic [NUM_TIE-1:0]   LO,
   output logic [NUM_TIE-1:0]   HI
);

   chain_op_e        chain_op;
   logic [DEPTH-1:0] chain_d;
   logic [DEPTH-1:0] chain_q;

   // Per-bit tie cell + buffer so each output can be rewired alone
   for (genvar i = 0; i < NUM_TIE; i++) begin : g_tie
      (* keep = "true", dont_touch = "true" *) logic tie_lo;
      (* keep = "true", dont_touch = "true" *) logic tie_hi;
      assign tie_lo = 1'b0;
      assign tie_hi = 1'b1;
      assign LO[i]  = tie_lo;
      assign HI[i]  = tie_hi;
`ifdef SCL180_SPARE_GATES_EN
      (* keep = "true", dont_touch = "true" *) logic g_inv;
      (* keep = "true", dont_touch = "true" *) logic g_nand;
      (* keep = "true", dont_touch = "true" *) logic g_nor;
      assign g_inv         = ~tie_lo;
      assign g_nand        = ~(tie_lo & tie_lo);
      assign g_nor         = ~(tie_lo | tie_lo);
      assign spare_inv[i]  = g_inv;
      assign spare_nand[i] = g_nand;
      assign spare_nor[i]  = g_nor;
`endif
   end

   always_comb begin
      chain_op = OP_HOLD;
      if (sh_clr) begin
         chain_op = OP_CLR;
      end else if (sh_en) begin
         chain_op = OP_SHIFT;
      end
   end

   always_comb begin
      chain_d = chain_q;
      unique case (chain_op)
         OP_CLR:   chain_d = '0;
         OP_SHIFT: chain_d = {chain_q[DEPTH-2:0], sh_in};
         default:  chain_d = chain_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign sh_par = chain_q;
   assign sh_out = chain_q[DEPTH-1];

   scl180_spare_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_cnt (
      .clk      (clk),
      .resetn   (resetn),
      .cnt_en   (cnt_en),
      .cnt_load (cnt_load),
      .cnt_din  (cnt_din),
      .cnt_q    (cnt_q),
      .cnt_tc   (cnt_tc)
   );

endmodule

// File: tb/tb_scl180_macro_sparecell_bank.sv
// Self-checking bench for scl180_macro_sparecell_bank.
// Directed vectors plus a per-cycle comparison against a behavioural model.
module tb_scl180_macro_sparecell_bank;

   localparam int NT = 4;
   localparam int DP = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          sh_en, sh_clr, sh_in;
   logic          sh_out;
   logic [DP-1:0] sh_par;
   logic          cnt_en, cnt_load;
   logic [CW-1:0] cnt_din;
   logic [CW-1:0] cnt_q;
   logic          cnt_tc;
   logic [NT-1:0] lo, hi;
`ifdef SCL180_SPARE_GATES_EN
   logic [NT-1:0] spare_inv, spare_nand, spare_nor;
`endif
`ifdef USE_POWER_PINS
   logic vpwr = 1'b1;
   logic vgnd = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   int m_chain;
   int m_cnt;
   int m_tc;

   always #5 clk = ~clk;

   scl180_macro_sparecell_bank #(
      .NUM_TIE   (NT),
      .DEPTH     (DP),
      .CNT_WIDTH (CW)
   ) dut (
`ifdef USE_POWER_PINS
      .VPWR       (vpwr),
      .VGND       (vgnd),
`endif
      .clk        (clk),
      .resetn     (resetn),
      .sh_en      (sh_en),
      .sh_clr     (sh_clr),
      .sh_in      (sh_in),
      .sh_out     (sh_out),
      .sh_par     (sh_par),
      .cnt_en     (cnt_en),
      .cnt_load   (cnt_load),
      .cnt_din    (cnt_din),
      .cnt_q      (cnt_q),
      .cnt_tc     (cnt_tc),
`ifdef SCL180_SPARE_GATES_EN
      .spare_inv  (spare_inv),
      .spare_nand (spare_nand),
      .spare_nor  (spare_nor),
`endif
      .LO         (lo),
      .HI         (hi)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: chain as an integer shift register, counter as modular int
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_chain = 0;
         m_cnt   = 0;
         m_tc    = 0;
      end else begin
         if (sh_clr)
            m_chain = 0;
         else if (sh_en)
            m_chain = (m_chain * 2 + int'(sh_in)) % (2 ** DP);
         if (cnt_load) begin
            m_cnt = int'(cnt_din);
            m_tc  = 0;
         end else if (cnt_en) begin
            m_tc  = (m_cnt == 2 ** CW - 1) ? 1 : 0;
            m_cnt = (m_cnt + 1) % (2 ** CW);
         end else begin
            m_tc = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_par", 32'(sh_par), m_chain);
      chk("m_out", 32'(sh_out), (m_chain / (2 ** (DP - 1))) % 2);
      chk("m_cnt", 32'(cnt_q), m_cnt);
      chk("m_tc", 32'(cnt_tc), m_tc);
      chk("m_lo", 32'(lo), 0);
      chk("m_hi", 32'(hi), 2 ** NT - 1);
   end

   initial begin
      logic [7:0] pat;
      resetn   = 1'b0;
      sh_en    = 1'b0;
      sh_clr   = 1'b0;
      sh_in    = 1'b0;
      cnt_en   = 1'b0;
      cnt_load = 1'b0;
      cnt_din  = '0;
      #2;
      chk("rst_par", 32'(sh_par), 0);
      chk("rst_out", 32'(sh_out), 0);
      chk("rst_cnt", 32'(cnt_q), 0);
      chk("rst_tc", 32'(cnt_tc), 0);
      chk("rst_lo", 32'(lo), 0);
      chk("rst_hi", 32'(hi), 32'hF);
      tick();
      tick();
      resetn = 1'b1;

      // single 1 walks bit0 -> bit7
      sh_en = 1'b1;
      sh_in = 1'b1;
      for (int k = 1; k <= DP; k++) begin
         tick();
         chk("walk_par", 32'(sh_par), 32'(1) << (k - 1));
         sh_in = 1'b0;
      end
      chk("walk_out8", 32'(sh_out), 1);
      tick();
      chk("walk_drain", 32'(sh_par), 0);

      // edges 4..6 disabled: arrival on edge 11
      sh_in = 1'b1;
      for (int e = 1; e <= 11; e++) begin
         tick();
         chk("gap_out", 32'(sh_out), (e == 11) ? 1 : 0);
         sh_in = 1'b0;
         sh_en = !((e + 1) >= 4 && (e + 1) <= 6);
      end
      chk("gap_model", m_chain, 32'h80);

      // load 0xA5 serially, then clear beats shift
      pat   = 8'hA5;
      sh_en = 1'b1;
      for (int i = 0; i < DP; i++) begin
         sh_in = pat[7-i];
         tick();
      end
      sh_en = 1'b0;
      sh_in = 1'b0;
      chk("a5_par", 32'(sh_par), 32'hA5);
      sh_clr = 1'b1;
      sh_en  = 1'b1;
      sh_in  = 1'b1;
      tick();
      chk("clr_par", 32'(sh_par), 0);
      sh_clr = 1'b0;
      sh_en  = 1'b0;
      sh_in  = 1'b0;

      // wrap FE -> FF -> 00(tc) -> 01
      cnt_load = 1'b1;
      cnt_din  = 8'hFE;
      tick();
      chk("wr_fe", 32'(cnt_q), 32'hFE);
      chk("wr_fe_tc", 32'(cnt_tc), 0);
      cnt_load = 1'b0;
      cnt_en   = 1'b1;
      tick();
      chk("wr_ff", 32'(cnt_q), 32'hFF);
      chk("wr_ff_tc", 32'(cnt_tc), 0);
      tick();
      chk("wr_00", 32'(cnt_q), 0);
      chk("wr_00_tc", 32'(cnt_tc), 1);
      tick();
      chk("wr_01", 32'(cnt_q), 1);
      chk("wr_01_tc", 32'(cnt_tc), 0);
      chk("wr_model", m_cnt, 1);
      cnt_en = 1'b0;

      // load wins over increment, no tc
      cnt_load = 1'b1;
      cnt_din  = 8'h10;
      tick();
      chk("ld_10", 32'(cnt_q), 32'h10);
      cnt_din = 8'h00;
      cnt_en  = 1'b1;
      tick();
      chk("ld_inc_q", 32'(cnt_q), 0);
      chk("ld_inc_tc", 32'(cnt_tc), 0);
      cnt_din = 8'hFF;
      cnt_en  = 1'b0;
      tick();
      cnt_din = 8'h00;
      cnt_en  = 1'b1;
      tick();
      chk("ld_ff0_q", 32'(cnt_q), 0);
      chk("ld_ff0_tc", 32'(cnt_tc), 0);
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      tick();
      chk("ld_hold_tc", 32'(cnt_tc), 0);

      // async reset mid-cycle with chain=FF, cnt=5A
      sh_en = 1'b1;
      sh_in = 1'b1;
      repeat (DP) tick();
      sh_en    = 1'b0;
      cnt_load = 1'b1;
      cnt_din  = 8'h5A;
      tick();
      cnt_load = 1'b0;
      chk("pre_par", 32'(sh_par), 32'hFF);
      chk("pre_cnt", 32'(cnt_q), 32'h5A);
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("ar_par", 32'(sh_par), 0);
      chk("ar_out", 32'(sh_out), 0);
      chk("ar_cnt", 32'(cnt_q), 0);
      chk("ar_tc", 32'(cnt_tc), 0);
      chk("ar_lo", 32'(lo), 0);
      chk("ar_hi", 32'(hi), 32'hF);
      sh_en  = 1'b1;
      cnt_en = 1'b1;
      tick();
      tick();
      chk("hold_par", 32'(sh_par), 0);
      chk("hold_cnt", 32'(cnt_q), 0);
      resetn = 1'b1;
      tick();
      chk("resume_par", 32'(sh_par), 1);
      chk("resume_cnt", 32'(cnt_q), 1);
      sh_en  = 1'b0;
      sh_in  = 1'b0;
      cnt_en = 1'b0;
      tick();

`ifdef SCL180_SPARE_GATES_EN
      chk("sp_inv", 32'(spare_inv), 32'hF);
      chk("sp_nand", 32'(spare_nand), 32'hF);
      chk("sp_nor", 32'(spare_nor), 32'hF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scl180_macro_sparecell_bank.md
Name: scl180_macro_sparecell_bank

Overview:
Parametrised ECO spare-logic bank for the SCL180 flow; next generation of the single tie-low spare cell.
- Provides a bus of tie-low/tie-high outputs.
- Provides a resettable spare flop shift chain and a loadable spare counter, so metal-only ECOs can add delay stages, retiming or event counting without new base layers.
- Instanced per floorplan region; inputs are tied inactive at integration unless an ECO rewires them.

Parameters:
NUM_TIE, 4, width of LO/HI tie buses (>=1)
DEPTH, 8, spare shift-chain length in flops (>=2)
CNT_WIDTH, 8, spare counter width in bits (>=2)

Ports:
clk  input  1  bank clock
resetn  input  1  asynchronous active-low reset
sh_en  input  1  shift-chain advance enable
sh_clr  input  1  synchronous clear of shift chain
sh_in  input  1  shift-chain serial input
sh_out  output  1  last chain stage
sh_par  output  DEPTH  parallel view of chain, bit 0 = first stage
cnt_en  input  1  counter increment enable
cnt_load  input  1  synchronous counter load
cnt_din  input  CNT_WIDTH  load value
cnt_q  output  CNT_WIDTH  counter value
cnt_tc  output  1  terminal-count flag
LO  output  NUM_TIE  constant 0
HI  output  NUM_TIE  constant 1
VPWR, VGND  input  1  power pins, present only under USE_POWER_PINS

Behaviour:
- Clock and reset: one clock `clk`; reset `resetn` is asynchronous, active-low. Asserting `resetn` low clears all flops immediately, regardless of `clk`.
- Reset values: sh_par=0, sh_out=0, cnt_q=0, cnt_tc=0. LO=0 and HI=1 at all times, including during reset.
- Tie outputs:
  - LO is driven from a tie-low through a buffer.
  - HI is driven from a tie-high through a buffer.
  - Each bit has its own buffer; no flop in the path.
- Shift chain, evaluated at clk rising edge, in priority order:
  1. sh_clr=1: all stages <= 0; sh_en ignored.
  2. sh_en=1: stage0 <= sh_in, stage[i] <= stage[i-1].
  3. otherwise: hold.
- Shift-chain outputs:
  - sh_out = stage[DEPTH-1].
  - A bit applied at sh_in appears on sh_out after exactly DEPTH enabled edges. Gaps with sh_en=0 stretch latency; no data is lost.
- Counter, evaluated at clk rising edge, in priority order:
  1. cnt_load=1: cnt_q <= cnt_din; cnt_en ignored.
  2. cnt_en=1: cnt_q <= cnt_q+1, modulo 2^CNT_WIDTH.
  3. otherwise: hold.
- Counter wrap: all-ones + 1 = 0; no saturation.
- cnt_tc is registered. It is 1 for exactly the one cycle following an edge where cnt_q wrapped from all-ones to 0 via increment. A load of 0 does not set cnt_tc.
- Load and increment together: load wins; no tc is generated.
- Reset mid-operation: chain and counter clear asynchronously. Shift/count resumes on the first rising edge after resetn deasserts; no partial shift.
- Reset deassertion is assumed synchronised upstream; no internal synchroniser.
- No combinational path from any input to any output except the tie buses (which are constant).

Optional Feature:
SCL180_SPARE_GATES_EN.
- Defined: adds a free-gate pool per NUM_TIE bit: one inverter, one 2-input NAND and one 2-input NOR, all inputs tied to the local tie-low.
  - Outputs exported on spare_inv, spare_nand, spare_nor, each NUM_TIE wide.
  - Required constant values: spare_inv = all-ones, spare_nand = all-ones, spare_nor = all-ones.
  - These gates exist only as ECO raw material and must survive synthesis (keep/dont_touch attribute).
- Undefined: those ports and gates are absent; all other behaviour is unchanged.

Decomposition:
- Package scl180_spare_pkg:
  - Default constants SPARE_NUM_TIE_DEF=4, SPARE_DEPTH_DEF=8, SPARE_CNT_WIDTH_DEF=8.
  - Enumerated priority encoding for chain ops: OP_HOLD, OP_SHIFT, OP_CLR.
- One sub-module, scl180_spare_cnt, contains the counter plus cnt_tc logic, parametrised by CNT_WIDTH.
- The shift chain and tie buses stay in the top.

Test Plan:
- Reset: resetn low mid-cycle with cnt_q=0x5A and chain=0xFF -> all flops 0 immediately; LO=0, HI=1 throughout.
- Shift latency: DEPTH=8; sh_en=1; drive sh_in 1 for one cycle then 0 -> sh_out=1 on exactly the 8th edge, sh_par walks a single 1 from bit0 to bit7. Repeat with sh_en dropped for 3 cycles mid-stream -> arrival at the 8th enabled edge (11th edge).
- Clear priority: chain=0xA5; assert sh_clr and sh_en with sh_in=1 together -> chain=0x00 next edge.
- Wrap: CNT_WIDTH=8; load 0xFE, then cnt_en=1 -> 0xFF, 0x00 with cnt_tc=1 for one cycle, then 0x01 with cnt_tc=0.
- Load vs increment: cnt_q=0x10; cnt_load=1, cnt_din=0x00, cnt_en=1 -> cnt_q=0x00 and cnt_tc stays 0.
- Optional feature: with SCL180_SPARE_GATES_EN, NUM_TIE=4 -> spare_inv=spare_nand=spare_nor=4'hF. Without the macro, the bench compiles and all other checks pass.
